inst_issuer: RTL and testbench
==============================

Name: inst_issuer

Overview:
- Initiator side of the instruction valid/ready interface into the array controller.
- A host loads a batch of instruction_t words into an internal FIFO. On go_i, the block issues them in order to the controller and honours its ready/stall back-pressure.
- Signals batch completion and exposes occupancy and issue statistics.
- Sits between the host/test-harness load path and the controller's instruction input.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_inst_i  in  $bits(instruction_t)  instruction word from the host.
- host_valid_i  in  1  host write valid.
- host_ready_o  out  1  FIFO can accept a word.
- go_i  in  1  start issuing the buffered batch (single-cycle pulse).
- flush_i  in  1  synchronous discard of buffered instructions.
- inst_o  out  $bits(instruction_t)  instruction to the controller.
- inst_valid_o  out  1  inst_o valid.
- inst_ready_i  in  1  controller accepts (low while it stalls on drain/issue hazards).
- busy_o  out  1  state is ISSUE.
- done_o  out  1  one-cycle pulse when a batch completes.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register.
- issued_cnt_o  out  CNT_W  handshakes completed since the last go_i.

Behaviour:
- One clock. Reset is asynchronous and active-low. All state clears on rst_ni low. Reset values: state=IDLE, pointers=0, inst_valid_o=0, inst_o=0, done_o=0, busy_o=0, issued_cnt_o=0, level_o=0.
- FIFO pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty: pointers are equal.
  - full: MSBs differ and the low bits are equal.
  - Wrap-around is natural modulo 2*DEPTH.
- Write: occurs when host_valid_i && host_ready_o. host_ready_o = !full, so there is no write-through when full.
- Simultaneous FIFO write and read in one cycle: level_o is unchanged.
- Output stage: a registered slot (inst_o / inst_valid_o).
  - Handshake occurs when inst_valid_o && inst_ready_i.
  - Once asserted, inst_valid_o stays high and inst_o stays stable until the handshake.
  - inst_valid_o never depends combinationally on inst_ready_i.
- Slot load: in ISSUE, the slot loads from the FIFO head when the FIFO is non-empty and the slot is empty or handshaking this cycle. This gives back-to-back issue at one instruction per cycle while ready stays high.
- Latency: first inst_valid_o is asserted 2 cycles after go_i, provided the FIFO is non-empty at go_i.
- FSM:
  - IDLE --go_i && !empty--> ISSUE. This transition clears issued_cnt_o.
  - go_i while empty or already in ISSUE is ignored.
  - ISSUE --FIFO empty && (slot empty or handshaking)--> IDLE, with done_o=1 for that cycle.
  - Host writes accepted during ISSUE are also issued (streaming). The batch ends only when the FIFO drains.
- issued_cnt_o increments on every handshake and saturates at all-ones.
- flush_i takes priority over writes and reads in the same cycle.
  - Pointers reset and level_o becomes 0.
  - A word already in the output slot is kept until it handshakes, so the protocol is never violated.
  - The FSM then enters IDLE with no done_o pulse.
  - A host write in the flush cycle is dropped, but host_ready_o still reflects the pre-flush state.
- Reset mid-batch: everything clears immediately and inst_valid_o drops asynchronously.

Optional Feature:
- Macro: INST_ISSUER_LOOP_EN.
- With the macro:
  - Adds input loop_cnt_i [7:0], sampled at go_i.
  - The batch present at go_i is replayed loop_cnt_i+1 times. A separate replay read pointer rewinds to the batch base after each pass.
  - Entries are freed only during the final pass.
  - host_ready_o is forced low in ISSUE so the batch stays intact.
  - done_o pulses once, after the last pass.
- Without the macro: loop_cnt_i is absent, behaviour is single-pass as above, and no replay logic is built.

Decomposition:
- instruction_t comes from common_pkg.
- Add to common_pkg: issuer_state_e {IDLE, ISSUE} and ISSUER_DEPTH_DEFAULT.
- One natural sub-module, inst_fifo (parameterised sync FIFO with level output). The FSM, output slot and counter stay in inst_issuer.

Test Plan:
1. DEPTH=4: write 3 words A,B,C, go_i, inst_ready_i=1 → inst_o = A,B,C on 3 consecutive cycles starting 2 cycles after go_i; done_o pulses once; issued_cnt_o=3; level_o=0.
2. Write 4 words → host_ready_o=0 and level_o=4; a 5th write attempt is not accepted; go_i then drains 4 words, and host_ready_o rises after the first FIFO read.
3. Back-pressure: inst_ready_i low for 5 cycles while B is presented → inst_o holds B and inst_valid_o holds 1 throughout; B is issued exactly once when ready rises.
4. flush_i while B is in the slot and C is queued → B still handshakes, C is never issued, level_o=0, no done_o, state=IDLE.
5. rst_ni low mid-batch → inst_valid_o=0, level_o=0 and busy_o=0 immediately; go_i after reset with an empty FIFO produces no issue and no done_o.
6. With INST_ISSUER_LOOP_EN: write A,B, loop_cnt_i=2, go_i → A,B,A,B,A,B issued; issued_cnt_o=6; one done_o; FIFO empty afterwards.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the array-controller front end: instruction word and issuer FSM states.
package common_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] operand;
    } instruction_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issuer_state_e;

    localparam int ISSUER_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction FIFO with wrap-bit pointers and occupancy output.
// With INST_ISSUER_LOOP_EN, pointers and a random-access peek port are exposed for batch replay.
module inst_fifo
    import common_pkg::*;
#(
    parameter int DEPTH = ISSUER_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush,
    input  logic                       wr_en,
    input  instruction_t               wr_data,
    input  logic                       rd_en,
    output instruction_t               rd_data,
    output logic                       empty,
    output logic                       full,
`ifdef INST_ISSUER_LOOP_EN
    output logic [$clog2(DEPTH):0]     rd_ptr,
    output logic [$clog2(DEPTH):0]     wr_ptr,
    input  logic [$clog2(DEPTH):0]     peek_ptr,
    output instruction_t               peek_data,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    instruction_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign wr_ok_s = wr_en && !full && !flush;
    assign rd_ok_s = rd_en && !empty && !flush;

`ifdef INST_ISSUER_LOOP_EN
    assign rd_ptr    = rd_ptr_r;
    assign wr_ptr    = wr_ptr_r;
    assign peek_data = mem_r[peek_ptr[AW-1:0]];
`endif

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; flush returns both pointers to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/inst_issuer.sv
// Instruction issuer: buffers a host batch and issues it over valid/ready to the array controller.
// Optional INST_ISSUER_LOOP_EN adds loop_cnt_i and replays the batch loop_cnt_i+1 times.
module inst_issuer
    import common_pkg::*;
#(
    parameter int DEPTH = ISSUER_DEPTH_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [$bits(instruction_t)-1:0] host_inst_i,
    input  logic                         host_valid_i,
    output logic                         host_ready_o,
    input  logic                         go_i,
    input  logic                         flush_i,
`ifdef INST_ISSUER_LOOP_EN
    input  logic [7:0]                   loop_cnt_i,
`endif
    output logic [$bits(instruction_t)-1:0] inst_o,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic [CNT_W-1:0]             issued_cnt_o
);

    localparam int PW = $clog2(DEPTH) + 1;

    issuer_state_e    state_r;
    instruction_t     slot_r;
    logic             slot_valid_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] cnt_r;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             handshake_s;
    logic             slot_free_s;
    logic             load_s;
    logic             batch_end_s;
    logic             go_s;
    instruction_t     head_s;
    instruction_t     load_data_s;
    logic [PW-1:0]    level_s;

    assign handshake_s = slot_valid_r && inst_ready_i;
    assign slot_free_s = !slot_valid_r || handshake_s;
    assign go_s        = go_i && (state_r == IDLE) && !fifo_empty_s && !flush_i;
    assign wr_en_s     = host_valid_i && host_ready_o && !flush_i;

`ifdef INST_ISSUER_LOOP_EN
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] fifo_rd_ptr_s;
    logic [PW-1:0] fifo_wr_ptr_s;
    logic [PW-1:0] rep_ptr_r;
    logic [PW-1:0] end_ptr_r;
    logic [7:0]    passes_left_r;
    logic          final_pass_s;
    logic          pass_end_s;
    instruction_t  peek_data_s;

    assign final_pass_s = (passes_left_r == 8'd0);
    assign pass_end_s   = (rep_ptr_r == end_ptr_r);
    assign batch_end_s  = final_pass_s && pass_end_s;
    assign load_s       = (state_r == ISSUE) && !flush_i && !pass_end_s && slot_free_s;
    // FIFO entries are only consumed on the last pass; earlier passes just walk the replay pointer.
    assign rd_en_s      = load_s && final_pass_s;
    assign host_ready_o = !fifo_full_s && (state_r != ISSUE);
    assign load_data_s  = peek_data_s;

    // Replay pointer, batch end snapshot and remaining pass count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_ptr_r     <= {PW{1'b0}};
            end_ptr_r     <= {PW{1'b0}};
            passes_left_r <= 8'd0;
        end else if (flush_i) begin
            rep_ptr_r     <= {PW{1'b0}};
            end_ptr_r     <= {PW{1'b0}};
            passes_left_r <= 8'd0;
        end else if (go_s) begin
            rep_ptr_r     <= fifo_rd_ptr_s;
            end_ptr_r     <= fifo_wr_ptr_s;
            passes_left_r <= loop_cnt_i;
        end else if (state_r == ISSUE) begin
            if (load_s) begin
                rep_ptr_r <= rep_ptr_r + PTR_ONE;
            end else if (pass_end_s && !final_pass_s) begin
                rep_ptr_r     <= fifo_rd_ptr_s;
                passes_left_r <= passes_left_r - 8'd1;
            end
        end
    end
`else
    assign batch_end_s  = fifo_empty_s;
    assign load_s       = (state_r == ISSUE) && !flush_i && !fifo_empty_s && slot_free_s;
    assign rd_en_s      = load_s;
    assign host_ready_o = !fifo_full_s;
    assign load_data_s  = head_s;
`endif

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush     (flush_i),
        .wr_en     (wr_en_s),
        .wr_data   (instruction_t'(host_inst_i)),
        .rd_en     (rd_en_s),
        .rd_data   (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
`ifdef INST_ISSUER_LOOP_EN
        .rd_ptr    (fifo_rd_ptr_s),
        .wr_ptr    (fifo_wr_ptr_s),
        .peek_ptr  (rep_ptr_r),
        .peek_data (peek_data_s),
`endif
        .level     (level_s)
    );

    // Issue FSM with registered busy and done flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush_i) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (go_s) begin
                            state_r <= ISSUE;
                            busy_r  <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (batch_end_s && slot_free_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output slot: holds its word until the controller accepts it, even across a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_r       <= '{opcode: 8'h00, operand: 24'h000000};
            slot_valid_r <= 1'b0;
        end else if (load_s) begin
            slot_r       <= load_data_s;
            slot_valid_r <= 1'b1;
        end else if (handshake_s) begin
            slot_valid_r <= 1'b0;
        end
    end

    // Saturating handshake counter, cleared when a batch starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (go_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (handshake_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign inst_o       = slot_r;
    assign inst_valid_o = slot_valid_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign level_o      = level_s;
    assign issued_cnt_o = cnt_r;

endmodule

// File: tb/tb_inst_issuer.sv
// Directed self-checking bench for inst_issuer (DEPTH=4); loop test built with INST_ISSUER_LOOP_EN.
module tb_inst_issuer;
    import common_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    localparam logic [31:0] WA = 32'h0A00_00A1;
    localparam logic [31:0] WB = 32'h0B00_00B2;
    localparam logic [31:0] WC = 32'h0C00_00C3;
    localparam logic [31:0] WX = 32'h0E00_00EE;

    logic        clk;
    logic        rst_ni;
    logic [31:0] host_inst;
    logic        host_valid;
    logic        host_ready;
    logic        go;
    logic        flush;
`ifdef INST_ISSUER_LOOP_EN
    logic [7:0]  loop_cnt;
`endif
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        busy;
    logic        done;
    logic [2:0]  level;
    logic [31:0] issued_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int hs_b     = 0;
    int hs_c     = 0;
    int hs_total = 0;
    int done_total = 0;

    inst_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .host_inst_i  (host_inst),
        .host_valid_i (host_valid),
        .host_ready_o (host_ready),
        .go_i         (go),
        .flush_i      (flush),
`ifdef INST_ISSUER_LOOP_EN
        .loop_cnt_i   (loop_cnt),
`endif
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .busy_o       (busy),
        .done_o       (done),
        .level_o      (level),
        .issued_cnt_o (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and done-pulse monitor.
    always @(posedge clk) begin
        if (rst_ni && inst_valid && inst_ready) begin
            hs_total <= hs_total + 1;
            if (inst == WB) hs_b <= hs_b + 1;
            if (inst == WC) hs_c <= hs_c + 1;
        end
        if (rst_ni && done) done_total <= done_total + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w);
        host_inst  = w;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        tick();
        tick();
        chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else pass_cnt++;
        chk_cnt++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else pass_cnt++;
        chk_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b want 00", {busy, done}); else pass_cnt++;
        chk_cnt++; if (level !== 3'd0) $display("FAIL rst_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++; if (issued_cnt !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", issued_cnt); else pass_cnt++;
        rst_ni = 1'b1;
        tick();
        chk_cnt++; if (host_ready !== 1'b1) $display("FAIL rst_host_ready: got %b want 1", host_ready); else pass_cnt++;
    endtask

    task automatic test_basic;
        write_word(WA); write_word(WB); write_word(WC);
        chk_cnt++; if (level !== 3'd3) $display("FAIL basic_level3: got %0d want 3", level); else pass_cnt++;
        inst_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_cnt++; if ({busy, inst_valid} !== 2'b10) $display("FAIL basic_lat1: got %b want 10", {busy, inst_valid}); else pass_cnt++;
        tick();
        chk_cnt++; if ({inst_valid, inst} !== {1'b1, WA}) $display("FAIL basic_a: got %b/%h want 1/%h", inst_valid, inst, WA); else pass_cnt++;
        tick();
        chk_cnt++; if ({inst_valid, inst} !== {1'b1, WB}) $display("FAIL basic_b: got %b/%h want 1/%h", inst_valid, inst, WB); else pass_cnt++;
        tick();
        chk_cnt++; if ({inst_valid, inst} !== {1'b1, WC}) $display("FAIL basic_c: got %b/%h want 1/%h", inst_valid, inst, WC); else pass_cnt++;
        tick();
        chk_cnt++; if ({done, inst_valid, busy} !== 3'b100) $display("FAIL basic_done: got %b want 100", {done, inst_valid, busy}); else pass_cnt++;
        chk_cnt++; if (issued_cnt !== 32'd3) $display("FAIL basic_cnt: got %0d want 3", issued_cnt); else pass_cnt++;
        chk_cnt++; if (level !== 3'd0) $display("FAIL basic_level0: got %0d want 0", level); else pass_cnt++;
        tick();
        chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_full;
        logic [31:0] d [4];
        d[0] = 32'h1000_0001; d[1] = 32'h1000_0002; d[2] = 32'h1000_0003; d[3] = 32'h1000_0004;
        for (int i = 0; i < 4; i++) write_word(d[i]);
        chk_cnt++; if ({host_ready, level} !== {1'b0, 3'd4}) $display("FAIL full_state: got %b/%0d want 0/4", host_ready, level); else pass_cnt++;
        write_word(WX);
        chk_cnt++; if (level !== 3'd4) $display("FAIL full_reject: got %0d want 4", level); else pass_cnt++;
        inst_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_cnt++; if (host_ready !== 1'b0) $display("FAIL full_ready_hold: got %b want 0", host_ready); else pass_cnt++;
        tick();
        chk_cnt++; if ({host_ready, level} !== {1'b1, 3'd3}) $display("FAIL full_ready_rise: got %b/%0d want 1/3", host_ready, level); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if ({inst_valid, inst} !== {1'b1, d[i]}) $display("FAIL full_drain%0d: got %b/%h want 1/%h", i, inst_valid, inst, d[i]); else pass_cnt++;
            tick();
        end
        chk_cnt++; if ({done, issued_cnt} !== {1'b1, 32'd4}) $display("FAIL full_done: got %b/%0d want 1/4", done, issued_cnt); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_pressure;
        int b0;
        b0 = hs_b;
        write_word(WA); write_word(WB); write_word(WC);
        inst_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if ({inst_valid, inst} !== {1'b1, WB}) $display("FAIL bp_hold%0d: got %b/%h want 1/%h", i, inst_valid, inst, WB); else pass_cnt++;
            tick();
        end
        chk_cnt++; if (hs_b - b0 !== 0) $display("FAIL bp_no_issue: got %0d want 0", hs_b - b0); else pass_cnt++;
        inst_ready = 1'b1;
        tick();
        chk_cnt++; if ({inst_valid, inst} !== {1'b1, WC}) $display("FAIL bp_next: got %b/%h want 1/%h", inst_valid, inst, WC); else pass_cnt++;
        tick();
        chk_cnt++; if ({done, issued_cnt} !== {1'b1, 32'd3}) $display("FAIL bp_done: got %b/%0d want 1/3", done, issued_cnt); else pass_cnt++;
        chk_cnt++; if (hs_b - b0 !== 1) $display("FAIL bp_once: got %0d want 1", hs_b - b0); else pass_cnt++;
        tick();
    endtask

    task automatic test_flush;
        int b0, c0, d0;
        b0 = hs_b; c0 = hs_c; d0 = done_total;
        write_word(WA); write_word(WB); write_word(WC);
        inst_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        inst_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_cnt++; if ({level, busy, done} !== {3'd0, 1'b0, 1'b0}) $display("FAIL flush_state: got %0d/%b/%b want 0/0/0", level, busy, done); else pass_cnt++;
        chk_cnt++; if ({inst_valid, inst} !== {1'b1, WB}) $display("FAIL flush_slot_kept: got %b/%h want 1/%h", inst_valid, inst, WB); else pass_cnt++;
        inst_ready = 1'b1;
        tick();
        chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL flush_slot_drained: got %b want 0", inst_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        chk_cnt++; if (hs_b - b0 !== 1) $display("FAIL flush_b_once: got %0d want 1", hs_b - b0); else pass_cnt++;
        chk_cnt++; if (hs_c - c0 !== 0) $display("FAIL flush_c_dropped: got %0d want 0", hs_c - c0); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 0) $display("FAIL flush_no_done: got %0d want 0", done_total - d0); else pass_cnt++;
        chk_cnt++; if ({busy, level} !== {1'b0, 3'd0}) $display("FAIL flush_idle: got %b/%0d want 0/0", busy, level); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int h0, d0;
        write_word(WA); write_word(WB); write_word(WC);
        inst_ready = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        chk_cnt++; if ({inst_valid, busy} !== 2'b11) $display("FAIL rmid_active: got %b want 11", {inst_valid, busy}); else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        chk_cnt++; if ({inst_valid, busy, level} !== {1'b0, 1'b0, 3'd0}) $display("FAIL rmid_async: got %b/%b/%0d want 0/0/0", inst_valid, busy, level); else pass_cnt++;
        tick();
        rst_ni = 1'b1;
        tick();
        h0 = hs_total; d0 = done_total;
        inst_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++; if ({inst_valid, busy} !== 2'b00) $display("FAIL rmid_go_empty: got %b want 00", {inst_valid, busy}); else pass_cnt++;
        chk_cnt++; if ((hs_total - h0) + (done_total - d0) !== 0) $display("FAIL rmid_no_issue: got %0d want 0", (hs_total - h0) + (done_total - d0)); else pass_cnt++;
    endtask

`ifdef INST_ISSUER_LOOP_EN
    task automatic test_loop;
        logic [31:0] seen [$];
        logic [31:0] expv [6];
        int d0;
        bit got_done;
        expv[0] = WA; expv[1] = WB; expv[2] = WA; expv[3] = WB; expv[4] = WA; expv[5] = WB;
        d0 = done_total;
        got_done = 1'b0;
        write_word(WA); write_word(WB);
        inst_ready = 1'b1;
        loop_cnt = 8'd2;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_cnt++; if (host_ready !== 1'b0) $display("FAIL loop_ready_low: got %b want 0", host_ready); else pass_cnt++;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (inst_valid) seen.push_back(inst);
            if (done) got_done = 1'b1;
            else tick();
        end
        chk_cnt++; if (!got_done) $display("FAIL loop_timeout: got no done want done"); else pass_cnt++;
        chk_cnt++; if (seen.size() !== 6) $display("FAIL loop_len: got %0d want 6", seen.size()); else pass_cnt++;
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            chk_cnt++; if (seen[i] !== expv[i]) $display("FAIL loop_word%0d: got %h want %h", i, seen[i], expv[i]); else pass_cnt++;
        end
        chk_cnt++; if ({issued_cnt, level} !== {32'd6, 3'd0}) $display("FAIL loop_cnt_level: got %0d/%0d want 6/0", issued_cnt, level); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (done_total - d0 !== 1) $display("FAIL loop_one_done: got %0d want 1", done_total - d0); else pass_cnt++;
    endtask
`endif

    initial begin
        rst_ni     = 1'b0;
        host_inst  = 32'h0;
        host_valid = 1'b0;
        go         = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
`ifdef INST_ISSUER_LOOP_EN
        loop_cnt   = 8'd0;
`endif
        test_reset();
        test_basic();
        test_full();
        test_back_pressure();
        test_flush();
        test_reset_mid();
`ifdef INST_ISSUER_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
